// File: rtl/pipeline_stall_controller.sv
// Central pipeline sequencer: merges load-use, branch-redirect and memory-wait requests
// into per-stage enables and flushes, with a memory-wait watchdog and saturating counters.
module pipeline_stall_controller #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 stall_pipeline_i,
  input  logic                 branch_taken_EXE_i,
  input  logic                 dmem_busy_MEM_i,
  output logic                 pc_en_o,
  output logic                 if_id_en_o,
  output logic                 id_exe_en_o,
  output logic                 exe_mem_en_o,
  output logic                 mem_wb_en_o,
  output logic                 flush_if_id_o,
  output logic                 flush_id_exe_o,
  output logic                 mem_wait_o,
  output logic                 fatal_err_o,
  output logic [CNT_WIDTH-1:0] stall_cycles_o,
  output logic [CNT_WIDTH-1:0] flush_count_o
);

  localparam logic STALL_PIPELINE = 1'b1;
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              rule_busy;
  logic              rule_branch;
  logic              rule_stall;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (dmem_busy_MEM_i) state_nxt = (MEM_TIMEOUT <= 1) ? ERROR : MEM_WAIT;
      end
      MEM_WAIT: begin
        if (!dmem_busy_MEM_i)           state_nxt = RUN;
        else if (wait_cnt == WAIT_LAST) state_nxt = ERROR;
      end
      ERROR:   state_nxt = ERROR;
      default: state_nxt = RUN;
    endcase
  end

  // Request priority: error freeze, memory wait, branch flush, load-use bubble
  always_comb begin
    rule_busy   = (state != ERROR) && dmem_busy_MEM_i;
    rule_branch = (state != ERROR) && !dmem_busy_MEM_i && branch_taken_EXE_i;
    rule_stall  = (state != ERROR) && !dmem_busy_MEM_i && !branch_taken_EXE_i &&
                  (stall_pipeline_i == STALL_PIPELINE);
  end

  always_comb begin
    pc_en_o        = 1'b0;
    if_id_en_o     = 1'b0;
    id_exe_en_o    = 1'b0;
    exe_mem_en_o   = 1'b0;
    mem_wb_en_o    = 1'b0;
    flush_if_id_o  = 1'b0;
    flush_id_exe_o = 1'b0;
    mem_wait_o     = (state == MEM_WAIT);
    if (!rst_i && (state != ERROR) && !dmem_busy_MEM_i) begin
      pc_en_o        = !rule_stall;
      if_id_en_o     = !rule_stall;
      id_exe_en_o    = 1'b1;
      exe_mem_en_o   = 1'b1;
      mem_wb_en_o    = 1'b1;
      flush_if_id_o  = rule_branch;
      flush_id_exe_o = rule_branch || rule_stall;
    end
  end

  // Watchdog count of consecutive busy edges; held once frozen in ERROR
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt <= '0;
    end else begin
      case (state)
        RUN:      wait_cnt <= dmem_busy_MEM_i ? WAIT_W'(1) : '0;
        MEM_WAIT: wait_cnt <= dmem_busy_MEM_i ? wait_cnt + WAIT_W'(1) : '0;
        default:  wait_cnt <= wait_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fatal_err_o    <= 1'b0;
      stall_cycles_o <= '0;
      flush_count_o  <= '0;
    end else begin
      fatal_err_o <= fatal_err_o || (state_nxt == ERROR);
      if (rule_busy || rule_stall) stall_cycles_o <= sat_inc(stall_cycles_o);
      if (rule_branch)             flush_count_o  <= sat_inc(flush_count_o);
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench: default instance for the main sequencing, a MEM_TIMEOUT=4/CNT_WIDTH=4
// instance for watchdog and saturation, and a MEM_TIMEOUT=1 instance for the immediate error.
module tb_pipeline_stall_controller;

  logic clk = 1'b0;
  logic rst;
  logic stall, branch, busy;

  logic pc0, ifid0, idexe0, exemem0, memwb0, fif0, fid0, mw0, fatal0;
  logic [15:0] stallc0, flushc0;
  logic pc1, ifid1, idexe1, exemem1, memwb1, fif1, fid1, mw1, fatal1;
  logic [3:0] stallc1, flushc1;
  logic pc2, ifid2, idexe2, exemem2, memwb2, fif2, fid2, mw2, fatal2;
  logic [15:0] stallc2, flushc2;

  logic [6:0] ctl0, ctl1, ctl2;
  assign ctl0 = {pc0, ifid0, idexe0, exemem0, memwb0, fif0, fid0};
  assign ctl1 = {pc1, ifid1, idexe1, exemem1, memwb1, fif1, fid1};
  assign ctl2 = {pc2, ifid2, idexe2, exemem2, memwb2, fif2, fid2};

  localparam logic [6:0] CTL_RUN   = 7'b1111100;
  localparam logic [6:0] CTL_STALL = 7'b0011101;
  localparam logic [6:0] CTL_FLUSH = 7'b1111111;
  localparam logic [6:0] CTL_FROZE = 7'b0000000;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_stall0 = 0;
  int exp_flush0 = 0;
  int exp_stall1 = 0;

  always #5 clk = ~clk;

  pipeline_stall_controller dut0 (
    .clk_i(clk), .rst_i(rst), .stall_pipeline_i(stall), .branch_taken_EXE_i(branch),
    .dmem_busy_MEM_i(busy), .pc_en_o(pc0), .if_id_en_o(ifid0), .id_exe_en_o(idexe0),
    .exe_mem_en_o(exemem0), .mem_wb_en_o(memwb0), .flush_if_id_o(fif0),
    .flush_id_exe_o(fid0), .mem_wait_o(mw0), .fatal_err_o(fatal0),
    .stall_cycles_o(stallc0), .flush_count_o(flushc0)
  );

  pipeline_stall_controller #(.MEM_TIMEOUT(4), .CNT_WIDTH(4)) dut1 (
    .clk_i(clk), .rst_i(rst), .stall_pipeline_i(stall), .branch_taken_EXE_i(branch),
    .dmem_busy_MEM_i(busy), .pc_en_o(pc1), .if_id_en_o(ifid1), .id_exe_en_o(idexe1),
    .exe_mem_en_o(exemem1), .mem_wb_en_o(memwb1), .flush_if_id_o(fif1),
    .flush_id_exe_o(fid1), .mem_wait_o(mw1), .fatal_err_o(fatal1),
    .stall_cycles_o(stallc1), .flush_count_o(flushc1)
  );

  pipeline_stall_controller #(.MEM_TIMEOUT(1)) dut2 (
    .clk_i(clk), .rst_i(rst), .stall_pipeline_i(stall), .branch_taken_EXE_i(branch),
    .dmem_busy_MEM_i(busy), .pc_en_o(pc2), .if_id_en_o(ifid2), .id_exe_en_o(idexe2),
    .exe_mem_en_o(exemem2), .mem_wb_en_o(memwb2), .flush_if_id_o(fif2),
    .flush_id_exe_o(fid2), .mem_wait_o(mw2), .fatal_err_o(fatal2),
    .stall_cycles_o(stallc2), .flush_count_o(flushc2)
  );

  task automatic set_in(input logic s, input logic b, input logic m);
    stall = s; branch = b; busy = m;
  endtask

  task automatic test_reset();
    set_in(0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++; if (ctl0 !== CTL_FROZE) begin n_bad++; $display("FAIL reset_ctl got=%b want=%b", ctl0, CTL_FROZE); end
    n_cmp++; if ({stallc0, flushc0} !== 32'd0) begin n_bad++; $display("FAIL reset_cnt got=%h want=0", {stallc0, flushc0}); end
    n_cmp++; if ({mw0, fatal0, fatal1, fatal2} !== 4'b0) begin n_bad++; $display("FAIL reset_flags got=%b want=0000", {mw0, fatal0, fatal1, fatal2}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 5; i++) begin
      set_in(0, 0, 0);
      #1;
      n_cmp++; if (ctl0 !== CTL_RUN) begin n_bad++; $display("FAIL idle_ctl[%0d] got=%b want=%b", i, ctl0, CTL_RUN); end
      n_cmp++; if (mw0 !== 1'b0) begin n_bad++; $display("FAIL idle_memwait[%0d] got=%b want=0", i, mw0); end
      @(negedge clk);
    end
    n_cmp++; if ({stallc0, flushc0} !== 32'd0) begin n_bad++; $display("FAIL idle_cnt got=%h want=0", {stallc0, flushc0}); end
  endtask

  task automatic test_stall();
    set_in(1, 0, 0);
    #1;
    n_cmp++; if (ctl0 !== CTL_STALL) begin n_bad++; $display("FAIL stall_ctl got=%b want=%b", ctl0, CTL_STALL); end
    @(negedge clk);
    set_in(0, 0, 0);
    exp_stall0++; exp_stall1++;
    n_cmp++; if (stallc0 !== 16'(exp_stall0)) begin n_bad++; $display("FAIL stall_cnt got=%0d want=%0d", stallc0, exp_stall0); end
    n_cmp++; if (flushc0 !== 16'(exp_flush0)) begin n_bad++; $display("FAIL stall_flushcnt got=%0d want=%0d", flushc0, exp_flush0); end
  endtask

  task automatic test_branch_stall();
    set_in(1, 1, 0);
    #1;
    n_cmp++; if (ctl0 !== CTL_FLUSH) begin n_bad++; $display("FAIL brstall_ctl got=%b want=%b", ctl0, CTL_FLUSH); end
    @(negedge clk);
    set_in(0, 0, 0);
    exp_flush0++;
    n_cmp++; if (flushc0 !== 16'(exp_flush0)) begin n_bad++; $display("FAIL brstall_flushcnt got=%0d want=%0d", flushc0, exp_flush0); end
    n_cmp++; if (stallc0 !== 16'(exp_stall0)) begin n_bad++; $display("FAIL brstall_stallcnt got=%0d want=%0d", stallc0, exp_stall0); end
  endtask

  task automatic test_busy_branch();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1, 1);
      #1;
      n_cmp++; if (ctl0 !== CTL_FROZE) begin n_bad++; $display("FAIL busy_ctl[%0d] got=%b want=%b", i, ctl0, CTL_FROZE); end
      n_cmp++; if (mw0 !== (i > 0)) begin n_bad++; $display("FAIL busy_memwait[%0d] got=%b want=%b", i, mw0, (i > 0)); end
      @(negedge clk);
      exp_stall0++; exp_stall1++;
      if (i == 0) begin
        n_cmp++; if (fatal2 !== 1'b1) begin n_bad++; $display("FAIL t1_fatal got=%b want=1", fatal2); end
      end
    end
    set_in(0, 1, 0);
    #1;
    n_cmp++; if (ctl0 !== CTL_FLUSH) begin n_bad++; $display("FAIL wait_exit_ctl got=%b want=%b", ctl0, CTL_FLUSH); end
    n_cmp++; if (mw0 !== 1'b1) begin n_bad++; $display("FAIL wait_exit_memwait got=%b want=1", mw0); end
    n_cmp++; if (ctl2 !== CTL_FROZE) begin n_bad++; $display("FAIL t1_frozen_ctl got=%b want=%b", ctl2, CTL_FROZE); end
    @(negedge clk);
    set_in(0, 0, 0);
    exp_flush0++;
    n_cmp++; if (stallc0 !== 16'(exp_stall0)) begin n_bad++; $display("FAIL busy_stallcnt got=%0d want=%0d", stallc0, exp_stall0); end
    n_cmp++; if (flushc0 !== 16'(exp_flush0)) begin n_bad++; $display("FAIL busy_flushcnt got=%0d want=%0d", flushc0, exp_flush0); end
    n_cmp++; if ({mw0, fatal0, fatal1} !== 3'b000) begin n_bad++; $display("FAIL busy_after_flags got=%b want=000", {mw0, fatal0, fatal1}); end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 10; i++) begin
      set_in(0, 0, 1);
      #1;
      n_cmp++; if (ctl1 !== CTL_FROZE) begin n_bad++; $display("FAIL to_ctl[%0d] got=%b want=%b", i, ctl1, CTL_FROZE); end
      @(negedge clk);
      exp_stall0++;
      if (i < 4) exp_stall1++;
      n_cmp++; if (fatal1 !== (i >= 3)) begin n_bad++; $display("FAIL to_fatal[%0d] got=%b want=%b", i, fatal1, (i >= 3)); end
    end
    set_in(0, 0, 0);
    #1;
    n_cmp++; if (ctl1 !== CTL_FROZE) begin n_bad++; $display("FAIL to_frozen_ctl got=%b want=%b", ctl1, CTL_FROZE); end
    n_cmp++; if (ctl0 !== CTL_RUN) begin n_bad++; $display("FAIL to_dflt_ctl got=%b want=%b", ctl0, CTL_RUN); end
    @(negedge clk);
    n_cmp++; if (stallc1 !== 4'(exp_stall1)) begin n_bad++; $display("FAIL to_stallcnt got=%0d want=%0d", stallc1, exp_stall1); end
    n_cmp++; if (stallc0 !== 16'(exp_stall0)) begin n_bad++; $display("FAIL to_dflt_stallcnt got=%0d want=%0d", stallc0, exp_stall0); end
    n_cmp++; if ({fatal1, fatal0} !== 2'b10) begin n_bad++; $display("FAIL to_fatal_hold got=%b want=10", {fatal1, fatal0}); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if ({fatal1, fatal2} !== 2'b00) begin n_bad++; $display("FAIL areset_fatal got=%b want=00", {fatal1, fatal2}); end
    n_cmp++; if ({stallc1, flushc1} !== 8'd0) begin n_bad++; $display("FAIL areset_cnt got=%h want=0", {stallc1, flushc1}); end
    n_cmp++; if (ctl1 !== CTL_FROZE) begin n_bad++; $display("FAIL areset_ctl got=%b want=%b", ctl1, CTL_FROZE); end
    @(negedge clk);
    rst = 1'b0;
    exp_stall0 = 0; exp_flush0 = 0; exp_stall1 = 0;
    #1;
    n_cmp++; if (ctl1 !== CTL_RUN) begin n_bad++; $display("FAIL post_reset_ctl got=%b want=%b", ctl1, CTL_RUN); end
    n_cmp++; if (ctl2 !== CTL_RUN) begin n_bad++; $display("FAIL post_reset_t1_ctl got=%b want=%b", ctl2, CTL_RUN); end
    @(negedge clk);
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 20; i++) begin
      set_in(1, 0, 0);
      @(negedge clk);
      if (i == 13) begin
        n_cmp++; if (stallc1 !== 4'd14) begin n_bad++; $display("FAIL sat_pre got=%0d want=14", stallc1); end
      end
    end
    set_in(0, 0, 0);
    n_cmp++; if (stallc1 !== 4'd15) begin n_bad++; $display("FAIL sat_hold got=%0d want=15", stallc1); end
    n_cmp++; if (stallc0 !== 16'd20) begin n_bad++; $display("FAIL sat_wide got=%0d want=20", stallc0); end
    n_cmp++; if (flushc1 !== 4'd0) begin n_bad++; $display("FAIL sat_flushcnt got=%0d want=0", flushc1); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_stall();
    test_branch_stall();
    test_busy_branch();
    test_timeout();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
